// File: rtl/forward_hazard_unit_if.sv
// Bundle between the ID/EX pipeline control and the forwarding/hazard unit.
// The master side is the pipeline and the slave side is the hazard unit.
interface forward_hazard_unit_if #(
  parameter int REG_AW  = 5,
  parameter int NUM_SRC = 2,
  parameter int NUM_FWD = 2,
  parameter int CNT_W   = 16
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);

  logic [NUM_SRC*REG_AW-1:0] rs_ex;
  logic [NUM_SRC*REG_AW-1:0] rs_id;
  logic [NUM_SRC-1:0]        rs_valid_id;
  logic [NUM_FWD*REG_AW-1:0] rd_fwd;
  logic [NUM_FWD-1:0]        wr_fwd;
  logic [REG_AW-1:0]         rd_ex;
  logic                      wr_ex;
  logic                      load_ex;
  logic                      flush;
  logic [NUM_SRC*SEL_W-1:0]  fwd_sel;
  logic                      stall;
  logic                      bubble;
  logic [CNT_W-1:0]          stall_count;

  modport master (
    output rs_ex, rs_id, rs_valid_id, rd_fwd, wr_fwd, rd_ex, wr_ex, load_ex, flush,
    input  fwd_sel, stall, bubble, stall_count
  );

  modport slave (
    input  rs_ex, rs_id, rs_valid_id, rd_fwd, wr_fwd, rd_ex, wr_ex, load_ex, flush,
    output fwd_sel, stall, bubble, stall_count
  );
endinterface

// File: rtl/forward_hazard_unit.sv
// Operand forwarding selects plus load-use hazard stall FSM for the EX stage.
// Forwarding is purely combinational; the stall path holds PC/IF-ID and bubbles ID/EX.
module forward_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int NUM_SRC    = 2,
  parameter int NUM_FWD    = 2,
  parameter int LOAD_STALL = 1,
  parameter int CNT_W      = 16
) (
  input logic clk,
  input logic rst,
  forward_hazard_unit_if.slave bus
);
  localparam int SEL_W = $clog2(NUM_FWD + 1);
  localparam int REM_W = $clog2(LOAD_STALL + 1);

  typedef enum logic {IDLE, STALL} state_t;

  state_t                   state;
  state_t                   state_next;
  logic [REM_W-1:0]         rem;
  logic [REM_W-1:0]         rem_next;
  logic [CNT_W-1:0]         count;
  logic                     stall_int;
  logic                     haz;
  logic [NUM_SRC*SEL_W-1:0] sel;

  // Walk oldest to youngest so the youngest matching stage overwrites older ones.
  always_comb begin
    sel = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      for (int k = NUM_FWD - 1; k >= 0; k--) begin
        if (bus.wr_fwd[k] &&
            (bus.rd_fwd[k*REG_AW +: REG_AW] == bus.rs_ex[i*REG_AW +: REG_AW]) &&
            (bus.rs_ex[i*REG_AW +: REG_AW] != '0)) begin
          sel[i*SEL_W +: SEL_W] = SEL_W'(k + 1);
        end
      end
    end
  end

  always_comb begin
    haz = 1'b0;
    for (int i = 0; i < NUM_SRC; i++) begin
      if (bus.rs_valid_id[i] && (bus.rs_id[i*REG_AW +: REG_AW] == bus.rd_ex)) begin
        haz = 1'b1;
      end
    end
    haz = haz & bus.load_ex & bus.wr_ex & (bus.rd_ex != '0);
  end

  always_comb begin
    state_next = state;
    rem_next   = rem;
    stall_int  = 1'b0;
    case (state)
      IDLE: begin
        stall_int = haz & ~bus.flush;
        if (haz && !bus.flush && (LOAD_STALL > 1)) begin
          state_next = STALL;
          rem_next   = REM_W'(LOAD_STALL - 1);
        end
      end
      STALL: begin
        stall_int = ~bus.flush;
        rem_next  = rem - REM_W'(1);
        if (rem == REM_W'(1)) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
        rem_next   = '0;
      end
    endcase
    // Flush kills whatever is being stalled, so drop back to IDLE immediately.
    if (bus.flush) begin
      state_next = IDLE;
      rem_next   = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      rem   <= '0;
      count <= '0;
    end else begin
      state <= state_next;
      rem   <= rem_next;
      if (stall_int && (count != '1)) begin
        count <= count + CNT_W'(1);
      end
    end
  end

  assign bus.fwd_sel     = sel;
  assign bus.stall       = stall_int & ~rst;
  assign bus.bubble      = stall_int & ~rst;
  assign bus.stall_count = count;
endmodule

// File: tb/tb_forward_hazard_unit.sv
// Self-checking bench: two hazard units (LOAD_STALL=3/CNT_W=4 and LOAD_STALL=1/CNT_W=16)
// share one stimulus stream; expected values are queued and drained each cycle.
module tb_forward_hazard_unit;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [9:0] rs_ex;
  logic [9:0] rs_id;
  logic [9:0] rd_fwd;
  logic [1:0] rs_valid_id;
  logic [1:0] wr_fwd;
  logic [4:0] rd_ex;
  logic       wr_ex;
  logic       load_ex;
  logic       flush;

  always #5 clk = ~clk;

  forward_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .CNT_W(4))  bus3 ();
  forward_hazard_unit_if #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .CNT_W(16)) bus1 ();

  assign bus3.rs_ex       = rs_ex;
  assign bus3.rs_id       = rs_id;
  assign bus3.rs_valid_id = rs_valid_id;
  assign bus3.rd_fwd      = rd_fwd;
  assign bus3.wr_fwd      = wr_fwd;
  assign bus3.rd_ex       = rd_ex;
  assign bus3.wr_ex       = wr_ex;
  assign bus3.load_ex     = load_ex;
  assign bus3.flush       = flush;
  assign bus1.rs_ex       = rs_ex;
  assign bus1.rs_id       = rs_id;
  assign bus1.rs_valid_id = rs_valid_id;
  assign bus1.rd_fwd      = rd_fwd;
  assign bus1.wr_fwd      = wr_fwd;
  assign bus1.rd_ex       = rd_ex;
  assign bus1.wr_ex       = wr_ex;
  assign bus1.load_ex     = load_ex;
  assign bus1.flush       = flush;

  forward_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_STALL(3), .CNT_W(4)) dut3 (
    .clk (clk),
    .rst (rst),
    .bus (bus3)
  );

  forward_hazard_unit #(.REG_AW(5), .NUM_SRC(2), .NUM_FWD(2), .LOAD_STALL(1), .CNT_W(16)) dut1 (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  typedef enum int {S_FWD3, S_FWD1, S_STALL3, S_BUB3, S_CNT3, S_STALL1, S_BUB1, S_CNT1} sig_e;

  typedef struct {
    string       name;
    sig_e        sig;
    logic [31:0] exp;
  } chk_t;

  typedef struct {
    logic [9:0] rs_ex;
    logic [9:0] rd_fwd;
    logic [1:0] wr_fwd;
    logic [3:0] sel;
  } fwd_vec_t;

  chk_t     sb[$];
  fwd_vec_t tbl[8];
  int       vectors = 0;
  int       miscompares = 0;

  function automatic logic [31:0] actual(input sig_e s);
    case (s)
      S_FWD3:   return 32'(bus3.fwd_sel);
      S_FWD1:   return 32'(bus1.fwd_sel);
      S_STALL3: return 32'(bus3.stall);
      S_BUB3:   return 32'(bus3.bubble);
      S_CNT3:   return 32'(bus3.stall_count);
      S_STALL1: return 32'(bus1.stall);
      S_BUB1:   return 32'(bus1.bubble);
      S_CNT1:   return 32'(bus1.stall_count);
      default:  return 32'hdead_beef;
    endcase
  endfunction

  task automatic push_exp(input string name, input sig_e s, input logic [31:0] v);
    chk_t c;
    c.name = name;
    c.sig  = s;
    c.exp  = v;
    sb.push_back(c);
  endtask

  task automatic push_stall(input string name, input logic s3, input logic s1);
    push_exp({name, " stall3"},  S_STALL3, 32'(s3));
    push_exp({name, " bubble3"}, S_BUB3,   32'(s3));
    push_exp({name, " stall1"},  S_STALL1, 32'(s1));
    push_exp({name, " bubble1"}, S_BUB1,   32'(s1));
  endtask

  // Drives hazard-side inputs just after a rising edge.
  task automatic applyStimulus(input logic lo, input logic [4:0] rd, input logic [9:0] rsid,
                               input logic [1:0] vld, input logic fl);
    @(posedge clk);
    #1;
    load_ex     = lo;
    rd_ex       = rd;
    rs_id       = rsid;
    rs_valid_id = vld;
    flush       = fl;
  endtask

  // Samples mid-cycle and drains every expectation queued for this cycle.
  task automatic checkOutput();
    chk_t        c;
    logic [31:0] a;
    #3;
    while (sb.size() > 0) begin
      c = sb.pop_front();
      a = actual(c.sig);
      vectors++;
      if (a !== c.exp) begin
        miscompares++;
        $display("[TB] FAIL %s: got %0d, expected %0d", c.name, a, c.exp);
      end
    end
  endtask

  initial begin
    rs_ex = '0; rs_id = '0; rd_fwd = '0; rs_valid_id = '0; wr_fwd = '0;
    rd_ex = '0; wr_ex = 1'b1; load_ex = 1'b0; flush = 1'b0;

    tbl[0] = '{{5'd6, 5'd5},  {5'd6, 5'd5},  2'b11, 4'b1001};
    tbl[1] = '{{5'd6, 5'd5},  {5'd5, 5'd5},  2'b11, 4'b0001};
    tbl[2] = '{{5'd2, 5'd0},  {5'd0, 5'd0},  2'b11, 4'b0000};
    tbl[3] = '{{5'd2, 5'd0},  {5'd2, 5'd2},  2'b00, 4'b0000};
    tbl[4] = '{{5'd5, 5'd5},  {5'd5, 5'd5},  2'b10, 4'b1010};
    tbl[5] = '{{5'd31, 5'd3}, {5'd3, 5'd31}, 2'b11, 4'b0110};
    tbl[6] = '{{5'd8, 5'd9},  {5'd8, 5'd9},  2'b01, 4'b0001};
    tbl[7] = '{{5'd7, 5'd7},  {5'd7, 5'd7},  2'b11, 4'b0101};

    repeat (2) @(posedge clk);

    // Hazard presented while reset is held must not stall.
    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("reset gating", 1'b0, 1'b0);
    push_exp("reset count3", S_CNT3, 32'd0);
    push_exp("reset count1", S_CNT1, 32'd0);
    checkOutput();

    applyStimulus(1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
    rst = 1'b0;
    checkOutput();

    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
      rs_ex  = tbl[i].rs_ex;
      rd_fwd = tbl[i].rd_fwd;
      wr_fwd = tbl[i].wr_fwd;
      push_exp($sformatf("fwd_sel vec%0d dut3", i), S_FWD3, 32'(tbl[i].sel));
      push_exp($sformatf("fwd_sel vec%0d dut1", i), S_FWD1, 32'(tbl[i].sel));
      push_exp($sformatf("no stall vec%0d", i), S_STALL3, 32'd0);
      checkOutput();
    end

    // Load to x7 read by operand 1: three stall cycles vs. one.
    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("load-use c1", 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b0, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("load-use c2", 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("load-use c3", 1'b1, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("load-use c4", 1'b0, 1'b0);
    push_exp("load-use count3", S_CNT3, 32'd3);
    push_exp("load-use count1", S_CNT1, 32'd1);
    checkOutput();

    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b01, 1'b0);
    push_stall("operand invalid", 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 5'd0, {5'd0, 5'd0}, 2'b11, 1'b0);
    push_stall("rd x0", 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b1, 5'd9, {5'd3, 5'd9}, 2'b01, 1'b0);
    push_stall("operand0 hazard c1", 1'b1, 1'b1);
    checkOutput();
    repeat (2) begin
      applyStimulus(1'b0, 5'd9, {5'd3, 5'd9}, 2'b01, 1'b0);
      push_stall("operand0 hazard hold", 1'b1, 1'b0);
      checkOutput();
    end
    applyStimulus(1'b0, 5'd9, {5'd3, 5'd9}, 2'b01, 1'b0);
    push_stall("operand0 hazard end", 1'b0, 1'b0);
    push_exp("operand0 count3", S_CNT3, 32'd6);
    push_exp("operand0 count1", S_CNT1, 32'd2);
    checkOutput();

    // Reset, then flush on the second stall cycle.
    applyStimulus(1'b0, 5'd0, 10'd0, 2'b00, 1'b0);
    rst = 1'b1;
    checkOutput();
    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    rst = 1'b0;
    push_exp("post-reset count3", S_CNT3, 32'd0);
    push_exp("post-reset count1", S_CNT1, 32'd0);
    push_stall("flush c1", 1'b1, 1'b1);
    checkOutput();
    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b1);
    push_stall("flush c2", 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    push_stall("after flush", 1'b0, 1'b0);
    push_exp("flush count3", S_CNT3, 32'd1);
    push_exp("flush count1", S_CNT1, 32'd1);
    checkOutput();

    // Hazard held for 20 cycles: back-to-back stalls and counter saturation.
    for (int n = 0; n < 20; n++) begin
      applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
      push_stall($sformatf("held hazard c%0d", n + 1), 1'b1, 1'b1);
      checkOutput();
    end
    applyStimulus(1'b1, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    rst = 1'b1;
    push_exp("saturated count3", S_CNT3, 32'd15);
    push_exp("unsaturated count1", S_CNT1, 32'd21);
    push_stall("reset mid-stall", 1'b0, 1'b0);
    checkOutput();
    applyStimulus(1'b0, 5'd7, {5'd7, 5'd1}, 2'b11, 1'b0);
    rst = 1'b0;
    push_stall("after mid-stall reset", 1'b0, 1'b0);
    push_exp("mid-stall reset count3", S_CNT3, 32'd0);
    push_exp("mid-stall reset count1", S_CNT1, 32'd0);
    checkOutput();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
